// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus_timer register window: offsets, bit positions, reset values.
package bus_timer_pkg;

  localparam logic [2:0] OffCtrl     = 3'd0;
  localparam logic [2:0] OffPrescale = 3'd1;
  localparam logic [2:0] OffCount    = 3'd2;
  localparam logic [2:0] OffCompare  = 3'd3;
  localparam logic [2:0] OffStatus   = 3'd4;

  localparam int unsigned CtrlEnBit      = 0;
  localparam int unsigned CtrlIrqEnBit   = 1;
  localparam int unsigned StatusMatchBit = 0;
  localparam int unsigned StatusOvfBit   = 1;

  localparam logic [31:0] CompareRstVal = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for bus_timer: pulses tick once every (limit+1) enabled cycles.
module timer_prescaler #(
  parameter int unsigned Width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [Width-1:0] limit,
  output logic             tick
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == limit);
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer with prescaler, compare match and overflow flags.
// Define BUS_TIMER_AUTO_RELOAD_EN for periodic mode (COUNT reloads to 0 on a match tick).
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic        bus_write,
  input  logic        bus_read,
  output logic [31:0] bus_read_data,
  output logic        irq
);

  logic                  en_q, en_d, irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           count_q, count_d, compare_q, compare_d;
  logic                  match_q, match_d, ovf_q, ovf_d;

  logic       sel, tick, match_hit, ovf_hit;
  logic [2:0] off;
  logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic       unused_addr;

  assign unused_addr = ^bus_address[1:0];

  always_comb begin
    sel         = (bus_address[31:5] == BASE_ADDR[31:5]);
    off         = bus_address[4:2];
    wr_ctrl     = sel && bus_write && (off == OffCtrl);
    wr_prescale = sel && bus_write && (off == OffPrescale);
    wr_count    = sel && bus_write && (off == OffCount);
    wr_compare  = sel && bus_write && (off == OffCompare);
    wr_status   = sel && bus_write && (off == OffStatus);
  end

  timer_prescaler #(
    .Width(PRESCALE_W)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(en_q),
    .clear (wr_count || wr_prescale),
    .limit (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    match_hit = tick && (count_q == compare_q);
    ovf_hit   = tick && (count_q == 32'hFFFF_FFFF);

    en_d       = wr_ctrl ? bus_write_data[CtrlEnBit]    : en_q;
    irq_en_d   = wr_ctrl ? bus_write_data[CtrlIrqEnBit] : irq_en_q;
    prescale_d = wr_prescale ? bus_write_data[PRESCALE_W-1:0] : prescale_q;
    compare_d  = wr_compare ? bus_write_data : compare_q;

    // A bus store to COUNT overrides the tick increment.
    count_d = count_q;
    if (wr_count) begin
      count_d = bus_write_data;
    end else if (tick) begin
`ifdef BUS_TIMER_AUTO_RELOAD_EN
      count_d = match_hit ? 32'd0 : count_q + 32'd1;
`else
      count_d = count_q + 32'd1;
`endif
    end

    // Hardware set wins over a same-cycle write-1-to-clear.
    match_d = (match_q && !(wr_status && bus_write_data[StatusMatchBit])) || match_hit;
    ovf_d   = (ovf_q && !(wr_status && bus_write_data[StatusOvfBit])) || ovf_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      count_q    <= 32'd0;
      compare_q  <= CompareRstVal;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
    end
  end

  // Zero when not addressed so several responders can be OR-combined.
  always_comb begin
    bus_read_data = 32'd0;
    if (sel && bus_read) begin
      case (off)
        OffCtrl: begin
          bus_read_data[CtrlEnBit]    = en_q;
          bus_read_data[CtrlIrqEnBit] = irq_en_q;
        end
        OffPrescale: bus_read_data = 32'(prescale_q);
        OffCount:    bus_read_data = count_q;
        OffCompare:  bus_read_data = compare_q;
        OffStatus: begin
          bus_read_data[StatusMatchBit] = match_q;
          bus_read_data[StatusOvfBit]   = ovf_q;
        end
        default:     bus_read_data = 32'd0;
      endcase
    end
  end

  assign irq = match_q && irq_en_q;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: stimulus queues expectations, a negedge monitor checks them.
module tb_bus_timer;

  localparam logic [31:0] Base = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_address = 32'd0;
  logic [31:0] bus_write_data = 32'd0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [31:0] bus_read_data;
  logic        irq;
  logic        irq_chk = 1'b0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef BUS_TIMER_AUTO_RELOAD_EN
  localparam logic [31:0] AfterMatch = 32'd0;
`else
  localparam logic [31:0] AfterMatch = 32'd6;
`endif

  bus_timer dut (
    .clock         (clock),
    .reset         (reset),
    .bus_address   (bus_address),
    .bus_write_data(bus_write_data),
    .bus_write     (bus_write),
    .bus_read      (bus_read),
    .bus_read_data (bus_read_data),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  // Monitor: mid-cycle, pop and compare whatever the DUT is presenting.
  always @(negedge clock) begin
    exp_t e;
    if (bus_read) begin
      if (rd_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL rd_unexpected: no expectation queued, got %h", bus_read_data);
      end else begin
        e = rd_q.pop_front();
        n_cmp = n_cmp + 1;
        if (bus_read_data !== e.exp) begin
          n_bad = n_bad + 1;
          $display("FAIL %s: got %h expected %h", e.name, bus_read_data, e.exp);
        end
      end
    end else begin
      n_cmp = n_cmp + 1;
      if (bus_read_data !== 32'd0) begin
        n_bad = n_bad + 1;
        $display("FAIL rd_idle_zero: got %h expected 00000000", bus_read_data);
      end
    end
    if (irq_chk) begin
      if (irq_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL irq_unexpected: no expectation queued, got %b", irq);
      end else begin
        e = irq_q.pop_front();
        n_cmp = n_cmp + 1;
        if (irq !== e.exp[0]) begin
          n_bad = n_bad + 1;
          $display("FAIL %s: got %b expected %b", e.name, irq, e.exp[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    bus_write = 1'b0;
    bus_read  = 1'b0;
    irq_chk   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
    bus_address    = a;
    bus_write_data = d;
    bus_write      = 1'b1;
    step();
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    wr_addr(Base + 32'(off * 4), d);
  endtask

  task automatic rd_addr(input logic [31:0] a, input logic [31:0] e, input string nm);
    bus_address = a;
    bus_read    = 1'b1;
    rd_q.push_back('{e, nm});
    step();
  endtask

  task automatic rd(input int off, input logic [31:0] e, input string nm);
    rd_addr(Base + 32'(off * 4), e, nm);
  endtask

  task automatic rdwr(input int off, input logic [31:0] d, input logic [31:0] e, input string nm);
    bus_write      = 1'b1;
    bus_write_data = d;
    rd(off, e, nm);
  endtask

  task automatic chk_irq(input logic e, input string nm);
    irq_chk = 1'b1;
    irq_q.push_back('{{31'd0, e}, nm});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values and combinational read while reset is held.
    step();
    rd(3, 32'hFFFF_FFFF, "compare_during_reset");
    reset = 1'b0;
    rd(0, 32'd0, "ctrl_reset");
    rd(1, 32'd0, "prescale_reset");
    rd(2, 32'd0, "count_reset");
    rd(3, 32'hFFFF_FFFF, "compare_reset");
    rd(4, 32'd0, "status_reset");
    rd_addr(Base + 32'h14, 32'd0, "offset5_zero");
    rd_addr(Base + 32'h20, 32'd0, "unselected_zero");
    rd_addr(Base + 32'h0F, 32'hFFFF_FFFF, "byte_bits_ignored");
    wr_addr(Base + 32'h2C, 32'd0);
    rd(3, 32'hFFFF_FFFF, "unselected_write_ignored");

    // Prescaling: one increment per 4 cycles, then freeze.
    wr(1, 32'd3);
    rd(1, 32'd3, "prescale_readback");
    wr(0, 32'd1);
    idle(40);
    rd(2, 32'd10, "count_after_40");
    wr(0, 32'd0);
    idle(10);
    rd(2, 32'd10, "count_frozen");

    // Match and interrupt.
    do_reset();
    wr(3, 32'd5);
    wr(0, 32'd3);
    idle(5);
    chk_irq(1'b0, "irq_before_match");
    rd(2, 32'd5, "count_at_match");
    chk_irq(1'b1, "irq_after_match");
    rd(2, AfterMatch, "count_after_match");
    chk_irq(1'b1, "irq_held");
    wr(4, 32'd1);
    chk_irq(1'b0, "irq_cleared");
    rd(4, 32'd0, "status_cleared");

    // Overflow with COMPARE moved away from the wrap point.
    do_reset();
    wr(3, 32'd10);
    wr(2, 32'hFFFF_FFFE);
    wr(0, 32'd1);
    rd(2, 32'hFFFF_FFFE, "count_pre_ovf");
    rd(2, 32'hFFFF_FFFF, "count_max");
    rd(2, 32'd0, "count_wrapped");
    rd(4, 32'd2, "status_ovf");
    wr(4, 32'd2);
    rd(4, 32'd0, "ovf_cleared");

    // Collisions: store vs tick, W1C vs match, read/write same register, reset mid-count.
    do_reset();
    wr(0, 32'd3);
    wr(2, 32'd100);
    rd(2, 32'd100, "count_store_wins");
    wr(3, 32'd105);
    idle(3);
    chk_irq(1'b0, "irq_pre_collision");
    wr(4, 32'd1);
    chk_irq(1'b1, "irq_set_wins");
    rd(4, 32'd1, "match_set_wins");
    rdwr(3, 32'd7, 32'd105, "read_pre_edge");
    rd(3, 32'd7, "write_committed");
    reset = 1'b1;
    wr(2, 32'd55);
    reset = 1'b0;
    chk_irq(1'b0, "irq_after_reset");
    rd(0, 32'd0, "ctrl_after_reset");
    rd(1, 32'd0, "prescale_after_reset");
    rd(2, 32'd0, "count_after_reset");
    rd(3, 32'hFFFF_FFFF, "compare_after_reset");
    rd(4, 32'd0, "status_after_reset");

    // COUNT store clears the prescaler phase.
    do_reset();
    wr(1, 32'd3);
    wr(0, 32'd1);
    idle(1);
    wr(2, 32'd100);
    idle(3);
    rd(2, 32'd100, "count_pre_cleared");
    rd(2, 32'd101, "count_first_tick");

    step();
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d read and %0d irq expectations left, expected 0 and 0",
               rd_q.size(), irq_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0001_0000: 32-byte-aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE_W, default 16: width of the prescaler register.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port bus_address, input, 32: byte address from the core.
REQ-006 SHALL have port bus_write_data, input, 32: store data.
REQ-007 SHALL have port bus_write, input, 1: store strobe, one cycle per store.
REQ-008 SHALL have port bus_read, input, 1: load strobe.
REQ-009 SHALL have port bus_read_data, output, 32: load data.
REQ-010 SHALL have port irq, output, 1: level interrupt request.

Function
REQ-011 SHALL select the block when bus_address[31:5] == BASE_ADDR[31:5]; offset = bus_address[4:2]; bus_address[1:0] ignored.
REQ-012 SHALL implement this register map: 0 CTRL (bit0 EN, bit1 IRQ_EN, others read 0); 1 PRESCALE (PRESCALE_W bits, zero-extended); 2 COUNT; 3 COMPARE; 4 STATUS (bit0 MATCH, bit1 OVF; write-1-to-clear).
REQ-013 SHALL treat offsets 5-7 as reading 0, with writes ignored.
REQ-014 SHALL drive bus_read_data combinationally in the same cycle as the load (zero latency) when selected and bus_read=1, and 0 otherwise, so responders can be OR-combined.
REQ-015 SHALL commit a store on the clock edge that ends a cycle in which the block is selected and bus_write=1; an unselected bus_write SHALL have no effect.
REQ-016 SHALL hold, while EN=1, internal prescaler counter pre_cnt incrementing each cycle; when pre_cnt == PRESCALE, pre_cnt becomes 0 and tick=1 for that cycle. PRESCALE=0 ticks every cycle.
REQ-017 SHALL freeze pre_cnt and COUNT while EN=0.
REQ-018 SHALL increment COUNT by 1 on tick, modulo 2^32; on a 0xFFFF_FFFF->0 wrap, OVF is set.
REQ-019 SHALL set MATCH on a tick cycle in which COUNT == COMPARE, on the same edge as the count update.
REQ-020 SHALL drive irq = MATCH & IRQ_EN, derived only from registers with no combinational path from bus inputs.
REQ-021 SHALL give a store to COUNT priority over a same-cycle tick increment, and SHALL also clear pre_cnt.
REQ-022 SHALL clear pre_cnt on a store to PRESCALE.
REQ-023 SHALL give a hardware set of MATCH/OVF priority over a same-cycle W1C clear.
REQ-024 SHALL return the pre-edge register value for a load and store to the same register in one cycle.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set CTRL=0, PRESCALE=0, pre_cnt=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, irq=0.
REQ-026 SHALL give reset priority over any same-cycle store or tick; an in-progress prescale period is discarded.
REQ-027 SHALL keep bus_read_data combinational during reset and reflect the reset register values.

Configuration
REQ-028 SHALL, with macro BUS_TIMER_AUTO_RELOAD_EN defined, load COUNT with 0 instead of COMPARE+1 on a match tick (periodic mode, period (COMPARE+1)*(PRESCALE+1) cycles); OVF then sets only when COMPARE=32'hFFFF_FFFF.
REQ-029 SHALL, without the macro, let COUNT free-run through the match and wrap at 2^32.

Structure
REQ-030 SHALL place register offsets, CTRL/STATUS bit positions and the COMPARE reset value in shared package bus_timer_pkg.
REQ-031 SHALL implement the prescaler as sub-module timer_prescaler (inputs: enable, clear, limit; output: tick); decode, registers and match logic stay in bus_timer.

Verification
REQ-032 SHALL verify reset and read: after reset, loads at BASE+0x08 and BASE+0x0C -> 0 and 32'hFFFF_FFFF; load at BASE+0x14 -> 0; load at BASE+0x20 -> 0 (unselected).
REQ-033 SHALL verify prescaling: PRESCALE=3, CTRL=1 -> COUNT increments once every 4 cycles; after 40 cycles COUNT=10.
REQ-034 SHALL verify match and interrupt: PRESCALE=0, COMPARE=5, CTRL=3 -> irq rises the cycle after COUNT 5 is seen with a tick; W1C STATUS=1 -> irq falls next cycle; with the macro, COUNT reads 0 after the match, otherwise 6.
REQ-035 SHALL verify overflow: store COUNT=32'hFFFF_FFFE, PRESCALE=0, EN=1 -> COUNT goes 0xFFFF_FFFF, then 0; STATUS reads 2 (MATCH also set at 0xFFFF_FFFF unless COMPARE was changed).
REQ-036 SHALL verify collisions: store COUNT=100 on a tick cycle -> COUNT=100 next; W1C MATCH on a match cycle -> MATCH remains 1; reset asserted mid-count -> all registers at reset values next cycle.
